pipe_stage_skid: RTL and testbench
==================================

Name: pipe_stage_skid

Overview:
- Parametrised successor to the fixed IF/ID pipeline register: one pipeline stage carrying an instruction word and its PC.
- Adds a valid/ready handshake, a one-entry skid buffer (registered `in_ready`, full throughput) and a synchronous flush that inserts a NOP bubble.
- Sits between any two pipeline stages (IF/ID first, later ID/EX and others) in place of the bare register.

Parameters:
- INSTR_W, 32, instruction/payload word width in bits.
- PC_W, 32, PC width in bits.
- NOP_INSTR, 32'h00000013, value driven on `out_instr` whenever `out_valid`=0 (RV32I addi x0,x0,0); truncated or zero-extended to INSTR_W.
- PC_RST, 0, value of `out_pc` after reset and after flush.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  asynchronous active-low reset (asserted when 0).
- in_valid  in  1  upstream holds a valid word.
- in_ready  out  1  stage can accept; registered.
- in_instr  in  INSTR_W  upstream instruction.
- in_pc  in  PC_W  upstream PC.
- flush  in  1  synchronous kill of all held words (branch/jump redirect).
- out_valid  out  1  `out_instr`/`out_pc` hold a valid word.
- out_ready  in  1  downstream accepts this cycle.
- out_instr  out  INSTR_W  stage output instruction.
- out_pc  out  PC_W  stage output PC.

Behaviour:
- Storage:
  - Main register M (`out_*`, `out_valid`).
  - Skid register S (s_instr, s_pc, s_valid).
  - `in_ready` = !s_valid, driven from a flop (no combinational in→out path).
- Transfers: in_xfer = in_valid & in_ready; out_xfer = out_valid & out_ready.
- Reset (rst=0, immediate, asynchronous, any time including mid-transfer):
  - out_valid=0, s_valid=0, in_ready=1.
  - out_instr=NOP_INSTR, out_pc=PC_RST.
  - s_* data=0.
- Normal edge (flush=0). M is "free" when !out_valid | out_ready.
  - M free and s_valid: M<=S, s_valid<=0 (S drains first to preserve order; in_ready was 0, so no in_xfer).
  - M free, !s_valid, in_xfer: M<=input, out_valid<=1.
  - M free, !s_valid, !in_xfer: out_valid<=0, out_instr<=NOP_INSTR, out_pc holds.
  - M not free and in_xfer: S<=input, s_valid<=1 (next cycle in_ready=0).
  - M not free and !in_xfer: all hold.
- Ordering and integrity:
  - Words leave in acceptance order.
  - No word is dropped or duplicated except by flush.
  - Latency is 1 cycle from in_xfer to out_valid when M is free.
  - Throughput is 1 word/cycle with out_ready held 1.
- Output stability: while out_valid=1 and out_ready=0, `out_instr`/`out_pc` do not change.
- Flush (flush=1 at edge; priority over everything except reset):
  - out_valid<=0, s_valid<=0, in_ready<=1.
  - out_instr<=NOP_INSTR, out_pc<=PC_RST.
  - A same-cycle in_xfer is accepted and discarded.
  - A same-cycle out_xfer completes normally (downstream consumed it).
- Invariants:
  - s_valid=1 implies out_valid=1.
  - in_ready == !s_valid at every cycle.
- Width rules: payload copied bit-exact, no arithmetic; PC_W and INSTR_W are independent.

Test Plan:
- Reset: rst=0 mid-stream with out_valid=1, s_valid=1 → within the same cycle out_valid=0, in_ready=1, out_instr=32'h00000013, out_pc=0; after release, idle outputs unchanged.
- Streaming: out_ready=1, feed PC 0x00,0x04,0x08 with instr 0xA0,0xA1,0xA2 on consecutive cycles → out_* one cycle later, one per cycle; in_ready stays 1.
- Backpressure/skid: out_ready=0 after PC 0x04 reaches M, feed PC 0x08 → S captures it, in_ready=0 next cycle; PC 0x0C is held upstream; out_ready=1 → outputs 0x04,0x08,0x0C in order; nothing lost or duplicated.
- Flush with full stage: M=0x10, S=0x14, in_valid=1 (PC 0x18), flush=1 → next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=PC_RST, in_ready=1; 0x18 never appears; next accepted word (0x40) appears normally.
- Flush with out_xfer: out_ready=1, out_valid=1 (PC 0x20), flush=1 → 0x20 counted consumed once; stage empty afterward.
- Random: random in_valid/out_ready/flush (5%) over 10k cycles against a queue scoreboard → order preserved, out_* stable while stalled, in_ready==!s_valid every cycle.

Source files
------------

// File: rtl/pipe_stage_skid.sv
// One pipeline stage for an instruction word and its PC. A one-entry skid buffer
// keeps in_ready registered while still allowing one word per cycle; flush inserts a NOP.
module pipe_stage_skid #(
  parameter int                INSTR_W   = 32,
  parameter int                PC_W      = 32,
  parameter logic [31:0]       NOP_INSTR = 32'h00000013,
  parameter logic [PC_W-1:0]   PC_RST    = '0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [INSTR_W-1:0] in_instr,
  input  logic [PC_W-1:0]    in_pc,
  input  logic               flush,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [INSTR_W-1:0] out_instr,
  output logic [PC_W-1:0]    out_pc
);

  localparam logic [INSTR_W-1:0] NOP = INSTR_W'(NOP_INSTR);

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc;
  } word_t;

  word_t s_word;
  logic  s_valid;
  logic  in_xfer, m_free;

  assign in_xfer = in_valid & in_ready;
  assign m_free  = ~out_valid | out_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid <= 1'b0;
      out_instr <= NOP;
      out_pc    <= PC_RST;
      s_valid   <= 1'b0;
      s_word    <= '0;
      in_ready  <= 1'b1;
    end else if (flush) begin
      // Anything accepted this cycle is dropped along with the held words.
      out_valid <= 1'b0;
      out_instr <= NOP;
      out_pc    <= PC_RST;
      s_valid   <= 1'b0;
      in_ready  <= 1'b1;
    end else if (m_free) begin
      if (s_valid) begin
        // Skid drains before any new word so acceptance order is kept.
        out_valid <= 1'b1;
        out_instr <= s_word.instr;
        out_pc    <= s_word.pc;
        s_valid   <= 1'b0;
        in_ready  <= 1'b1;
      end else if (in_xfer) begin
        out_valid <= 1'b1;
        out_instr <= in_instr;
        out_pc    <= in_pc;
      end else begin
        out_valid <= 1'b0;
        out_instr <= NOP;
      end
    end else if (in_xfer) begin
      s_word   <= '{instr: in_instr, pc: in_pc};
      s_valid  <= 1'b1;
      in_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed and random checks of pipe_stage_skid against a depth-2 FIFO reference model.
module tb_pipe_stage_skid;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0, in_ready;
  logic [31:0] in_instr = '0, in_pc = '0;
  logic        flush = 1'b0;
  logic        out_valid, out_ready = 1'b0;
  logic [31:0] out_instr, out_pc;

  int checks = 0;
  int errors = 0;

  // Model: the stage behaves as a 2-deep FIFO of {pc, instr}; out_pc holds the
  // last presented pc when empty, PC_RST after reset/flush.
  logic [63:0] mq[$];
  logic [31:0] last_pc = '0;
  int          n20 = 0;

  pipe_stage_skid dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_instr(out_instr), .out_pc(out_pc)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_model();
    bit nonempty = (mq.size() > 0);
    chk("out_valid", {31'd0, out_valid}, {31'd0, nonempty});
    chk("in_ready",  {31'd0, in_ready},  {31'd0, mq.size() < 2});
    chk("out_instr", out_instr, nonempty ? mq[0][31:0] : 32'h00000013);
    chk("out_pc",    out_pc,    nonempty ? mq[0][63:32] : last_pc);
  endtask

  task automatic step(input bit iv, input logic [31:0] ii, input logic [31:0] ip,
                      input bit ordy, input bit fl);
    bit          inx, outx, stall;
    logic [31:0] pi, pp;
    in_valid = iv; in_instr = ii; in_pc = ip; out_ready = ordy; flush = fl;
    inx   = iv && (mq.size() < 2);
    outx  = ordy && (mq.size() > 0);
    stall = out_valid && !ordy && !fl;
    pi = out_instr; pp = out_pc;
    if (outx && mq[0][63:32] == 32'h20) n20++;
    if (fl) begin
      mq.delete();
      last_pc = '0;
    end else begin
      if (outx) void'(mq.pop_front());
      if (inx) mq.push_back({ip, ii});
      if (mq.size() > 0) last_pc = mq[0][63:32];
    end
    @(posedge clk);
    #1;
    check_model();
    if (stall) begin
      chk("stable_instr", out_instr, pi);
      chk("stable_pc", out_pc, pp);
    end
  endtask

  initial begin
    // Reset state
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_instr", out_instr, 32'h00000013);
    chk("rst_pc", out_pc, 32'd0);
    rst = 1'b1;

    // Streaming at full rate
    step(1, 32'hA0, 32'h00, 1, 0);
    step(1, 32'hA1, 32'h04, 1, 0);
    step(1, 32'hA2, 32'h08, 1, 0);
    step(0, 32'h0,  32'h0,  1, 0);

    // Backpressure into the skid buffer
    step(1, 32'hB1, 32'h04, 1, 0);
    step(1, 32'hB2, 32'h08, 0, 0);
    step(1, 32'hB3, 32'h0C, 0, 0);
    step(1, 32'hB3, 32'h0C, 1, 0);
    step(1, 32'hB3, 32'h0C, 1, 0);
    step(0, 32'h0,  32'h0,  1, 0);
    step(0, 32'h0,  32'h0,  1, 0);

    // Flush with both registers full and a same-cycle input
    step(1, 32'hC0, 32'h10, 1, 0);
    step(1, 32'hC1, 32'h14, 0, 0);
    step(1, 32'hC2, 32'h18, 0, 1);
    chk("flush_pc", out_pc, 32'd0);
    step(1, 32'hC4, 32'h40, 1, 0);
    step(0, 32'h0,  32'h0,  1, 0);

    // Flush coincident with an output transfer
    step(1, 32'hD0, 32'h20, 1, 0);
    step(0, 32'h0,  32'h0,  1, 1);
    step(0, 32'h0,  32'h0,  0, 0);
    chk("pc20_consumed_once", n20, 32'd1);

    // Asynchronous reset mid-stream with both registers full
    step(1, 32'hE0, 32'h50, 0, 0);
    step(1, 32'hE1, 32'h54, 0, 0);
    in_valid = 1'b0;
    #2 rst = 1'b0;
    #1;
    chk("arst_valid", {31'd0, out_valid}, 32'd0);
    chk("arst_ready", {31'd0, in_ready}, 32'd1);
    chk("arst_instr", out_instr, 32'h00000013);
    chk("arst_pc", out_pc, 32'd0);
    mq.delete();
    last_pc = '0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1 check_model();
    step(0, 32'h0, 32'h0, 0, 0);

    // Random traffic
    for (int i = 0; i < 10000; i++)
      step(($urandom % 4) != 0, $urandom, $urandom, ($urandom % 3) != 0,
           $urandom_range(0, 99) < 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
